// File: rtl/lane_serializer.sv
// Lane serializer: holds one multi-lane word and emits its lanes one beat at a time.
// Optional macro LANE_SERIALIZER_MSB_FIRST_EN reverses the mode-0 lane order.
module lane_serializer #(
   parameter int LANE_W = 8,
   parameter int LANES  = 4,
   parameter int SEL_W  = $clog2(LANES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [LANE_W-1:0]       out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_lane,
   output logic                    out_last
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [SEL_W-1:0] TOP_LANE = SEL_W'(LANES - 1);
`ifdef LANE_SERIALIZER_MSB_FIRST_EN
   localparam logic [SEL_W-1:0] FIRST_LANE = TOP_LANE;
   localparam logic [SEL_W-1:0] END_LANE   = '0;
`else
   localparam logic [SEL_W-1:0] FIRST_LANE = '0;
   localparam logic [SEL_W-1:0] END_LANE   = TOP_LANE;
`endif

   state_t                  state;
   state_t                  state_next;
   logic [LANES*LANE_W-1:0] word_q;
   logic                    mode_q;
   logic [SEL_W-1:0]        lane_q;
   logic [SEL_W-1:0]        lane_step;
   logic [SEL_W-1:0]        sel_clamped;
   logic                    accept;
   logic                    beat_done;
   logic                    last_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Accepting a word on the last-beat cycle keeps SEND, so words flow back to back.
   always_comb begin
      state_next = state;
      out_valid  = (state == SEND);
      out_last   = (state == SEND) && (mode_q || (lane_q == END_LANE));
      beat_done  = out_valid && out_ready;
      last_done  = beat_done && out_last;
      in_ready   = (state == IDLE) || last_done;
      accept     = in_valid && in_ready;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (last_done && !accept) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Out-of-range selects fall back to the top lane.
   always_comb begin
      sel_clamped = TOP_LANE;
      for (int i = 0; i < LANES; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_clamped = sel;
         end
      end
   end

`ifdef LANE_SERIALIZER_MSB_FIRST_EN
   assign lane_step = lane_q - SEL_W'(1);
`else
   assign lane_step = lane_q + SEL_W'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         mode_q <= 1'b0;
         lane_q <= '0;
      end else if (accept) begin
         word_q <= in_data;
         mode_q <= mode;
         lane_q <= mode ? sel_clamped : FIRST_LANE;
      end else if (beat_done && !out_last) begin
         lane_q <= lane_step;
      end
   end

   // Output lane is muxed purely from the held word, never from in_data.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_q == SEL_W'(i)) begin
            out_data = word_q[i*LANE_W +: LANE_W];
         end
      end
   end

   assign out_lane = lane_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: directed scenarios plus a randomized run
// against a beat-queue reference model.
`timescale 1ns/1ps
module tb_lane_serializer;

   localparam int LANES = 4;
`ifdef LANE_SERIALIZER_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_lane;
   logic        out_last;

   logic [23:0] in_data3;
   logic        in_valid3;
   logic        in_ready3;
   logic        mode3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic [1:0]  out_lane3;
   logic        out_last3;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0] exp_lane[$];
   logic [7:0] exp_data[$];
   logic       exp_last[$];

   always #5 clk = ~clk;

   lane_serializer #(.LANE_W(8), .LANES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane(out_lane), .out_last(out_last)
   );

   lane_serializer #(.LANE_W(8), .LANES(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3),
      .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
      .out_lane(out_lane3), .out_last(out_last3)
   );

   // Reference model: a word turns into the list of beats it must produce.
   function automatic void push_word(input logic [31:0] word, input logic m, input int s);
      int n;
      if (m) begin
         n = (s >= LANES) ? LANES - 1 : s;
         exp_lane.push_back(2'(n));
         exp_data.push_back(word[n*8 +: 8]);
         exp_last.push_back(1'b1);
      end else begin
         for (int k = 0; k < LANES; k++) begin
            n = MSB_FIRST ? LANES - 1 - k : k;
            exp_lane.push_back(2'(n));
            exp_data.push_back(word[n*8 +: 8]);
            exp_last.push_back(k == LANES - 1);
         end
      end
   endfunction

   function automatic void pop_beat();
      void'(exp_lane.pop_front());
      void'(exp_data.pop_front());
      void'(exp_last.pop_front());
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_lane !== 2'd0 || out_last !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got valid=%b data=%h lane=%0d last=%b, expected 0/00/0/0",
                  out_valid, out_data, out_lane, out_last);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL post_reset_idle: got valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_serialize();
      @(negedge clk);
      in_data = 32'hDDCCBBAA; mode = 1'b0; sel = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ser_accept: got in_ready=%b, expected 1", in_ready);
      end
      push_word(32'hDDCCBBAA, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b0; in_data = $urandom; mode = 1'b1; sel = 2'd3;
      for (int k = 0; k < LANES; k++) begin
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_lane !== exp_lane[0] || out_last !== exp_last[0]) begin
            miscompares++;
            $display("[TB] FAIL ser_beat%0d: got v=%b d=%h l=%0d last=%b, expected v=1 d=%h l=%0d last=%b",
                     k, out_valid, out_data, out_lane, out_last, exp_data[0], exp_lane[0], exp_last[0]);
         end
         pop_beat();
         @(negedge clk);
      end
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ser_idle: got valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_select();
      @(negedge clk);
      in_data = 32'hDDCCBBAA; mode = 1'b1; sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
      push_word(32'hDDCCBBAA, 1'b1, 2);
      @(negedge clk);
      in_valid = 1'b0; mode = 1'b0; sel = 2'd0; in_data = $urandom;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_lane !== exp_lane[0] || out_last !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL sel_beat: got v=%b d=%h l=%0d last=%b, expected v=1 d=%h l=%0d last=1",
                  out_valid, out_data, out_lane, out_last, exp_data[0], exp_lane[0]);
      end
      pop_beat();
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL sel_idle: got valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] pattern;
      pattern = 7'b1110001;
      @(negedge clk);
      in_data = 32'hDDCCBBAA; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      push_word(32'hDDCCBBAA, 1'b0, 0);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         in_valid = 1'b0; in_data = $urandom; mode = 1'($urandom_range(0, 1));
         out_ready = pattern[c];
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_lane !== exp_lane[0] || out_last !== exp_last[0]) begin
            miscompares++;
            $display("[TB] FAIL bp_cycle%0d: got v=%b d=%h l=%0d last=%b, expected v=1 d=%h l=%0d last=%b",
                     c, out_valid, out_data, out_lane, out_last, exp_data[0], exp_lane[0], exp_last[0]);
         end
         if (out_ready) pop_beat();
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bp_idle: got valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_data = 32'hDDCCBBAA; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      push_word(32'hDDCCBBAA, 1'b0, 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 3) begin
            in_valid = 1'b1; in_data = 32'h44332211; mode = 1'b0;
         end else begin
            in_valid = 1'b0; in_data = $urandom;
         end
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_lane !== exp_lane[0] || out_last !== exp_last[0]) begin
            miscompares++;
            $display("[TB] FAIL b2b_cycle%0d: got v=%b d=%h l=%0d last=%b, expected v=1 d=%h l=%0d last=%b",
                     c, out_valid, out_data, out_lane, out_last, exp_data[0], exp_lane[0], exp_last[0]);
         end
         if (c == 3) begin
            vectors++;
            if (in_ready !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL b2b_in_ready: got %b, expected 1", in_ready);
            end
            push_word(32'h44332211, 1'b0, 0);
         end
         pop_beat();
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_idle: got valid=%b, expected 0", out_valid);
      end
   endtask

   task automatic test_sel_clamp();
      int n;
      @(negedge clk);
      in_data3 = 24'hCCBBAA; mode3 = 1'b1; sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
      #1;
      vectors++;
      if (in_ready3 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL clamp_accept: got in_ready=%b, expected 1", in_ready3);
      end
      @(negedge clk);
      in_valid3 = 1'b0; in_data3 = 24'h0;
      #1;
      vectors++;
      if (out_valid3 !== 1'b1 || out_data3 !== 8'hCC || out_lane3 !== 2'd2 || out_last3 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL clamp_beat: got v=%b d=%h l=%0d last=%b, expected v=1 d=cc l=2 last=1",
                  out_valid3, out_data3, out_lane3, out_last3);
      end
      @(negedge clk);
      in_data3 = 24'h332211; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 1'b1;
      #1;
      vectors++;
      if (out_valid3 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL clamp_idle: got valid=%b, expected 0", out_valid3);
      end
      @(negedge clk);
      in_valid3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n = MSB_FIRST ? 2 - k : k;
         #1;
         vectors++;
         if (out_valid3 !== 1'b1 || out_data3 !== 8'(8'h11 * (n + 1)) || out_lane3 !== 2'(n) || out_last3 !== (k == 2)) begin
            miscompares++;
            $display("[TB] FAIL lanes3_beat%0d: got v=%b d=%h l=%0d last=%b, expected v=1 d=%h l=%0d last=%b",
                     k, out_valid3, out_data3, out_lane3, out_last3, 8'(8'h11 * (n + 1)), n, k == 2);
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lanes3_idle: got valid=%b in_ready=%b, expected 0/1", out_valid3, in_ready3);
      end
   endtask

   task automatic test_random();
      logic m_ready;
      logic has;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 9) < 6);
         in_data   = $urandom;
         mode      = ($urandom_range(0, 3) == 0);
         sel       = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         has     = (exp_data.size() != 0);
         m_ready = !has || (exp_data.size() == 1 && out_ready);
         vectors++;
         if (in_ready !== m_ready) begin
            miscompares++;
            $display("[TB] FAIL rand_in_ready cycle %0d: got %b, expected %b", c, in_ready, m_ready);
         end
         vectors++;
         if (out_valid !== has) begin
            miscompares++;
            $display("[TB] FAIL rand_out_valid cycle %0d: got %b, expected %b", c, out_valid, has);
         end
         if (has) begin
            vectors++;
            if (out_data !== exp_data[0] || out_lane !== exp_lane[0] || out_last !== exp_last[0]) begin
               miscompares++;
               $display("[TB] FAIL rand_beat cycle %0d: got d=%h l=%0d last=%b, expected d=%h l=%0d last=%b",
                        c, out_data, out_lane, out_last, exp_data[0], exp_lane[0], exp_last[0]);
            end
            if (out_ready) pop_beat();
         end
         if (in_valid && m_ready) push_word(in_data, mode, int'(sel));
      end
      // Let the last word drain so later scenarios start from IDLE.
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (LANES + 1) @(negedge clk);
      exp_lane.delete(); exp_data.delete(); exp_last.delete();
   endtask

   task automatic test_reset_mid_word();
      in_data = 32'hDDCCBBAA; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      push_word(32'hDDCCBBAA, 1'b0, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_lane !== exp_lane[0]) begin
            miscompares++;
            $display("[TB] FAIL mid_pre_beat%0d: got v=%b d=%h l=%0d, expected v=1 d=%h l=%0d",
                     c, out_valid, out_data, out_lane, exp_data[0], exp_lane[0]);
         end
         pop_beat();
      end
      @(negedge clk);
      rst_n = 1'b0;
      exp_lane.delete(); exp_data.delete(); exp_last.delete();
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_lane !== 2'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: got v=%b d=%h l=%0d last=%b in_ready=%b, expected 0/00/0/0/1",
                  out_valid, out_data, out_lane, out_last, in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_after_release%0d: got valid=%b in_ready=%b, expected 0/1",
                     c, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      in_data = '0; in_valid = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      in_data3 = '0; in_valid3 = 1'b0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
      test_reset();
      test_serialize();
      test_select();
      test_backpressure();
      test_back_to_back();
      test_sel_clamp();
      test_random();
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
